jtag_to_hps_bridge_b2p_adapter: RTL and testbench

JTAG_TO_HPS_BRIDGE_B2P_ADAPTER -- requirements
Module: jtag_to_hps_bridge_b2p_adapter

---
 rtl/jtag_to_hps_bridge_pkg.sv | 17 +
 rtl/jtag_to_hps_bridge_skid_fifo.sv | 60 ++++++
 rtl/jtag_to_hps_bridge_b2p_adapter.sv | 105 ++++++++++
 tb/tb_jtag_to_hps_bridge_b2p_adapter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_to_hps_bridge_pkg.sv
// Shared types and constants for the JTAG-to-HPS bridge byte-to-packet adapter.
package jtag_to_hps_bridge_pkg;

  localparam int unsigned FifoDepth = 2;

  typedef enum logic [0:0] {
    StIdle,
    StInPkt
  } frame_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } beat_t;

endpackage

// File: rtl/jtag_to_hps_bridge_skid_fifo.sv
// Two-entry FIFO; push_ready_o and pop_valid_o come only from registers.
module jtag_to_hps_bridge_skid_fifo
  import jtag_to_hps_bridge_pkg::*;
#(
  parameter int unsigned Width = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  output logic             push_ready_o,
  input  logic             pop_i,
  output logic [Width-1:0] pop_data_o,
  output logic             pop_valid_o
);

  logic [Width-1:0] mem_q [FifoDepth];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  // Holds ready low until the first clock edge after reset release.
  logic             live_q;
  logic             do_push, do_pop;

  assign pop_valid_o  = (count_q != 2'd0);
  assign push_ready_o = live_q && (count_q < 2'(FifoDepth));
  assign pop_data_o   = mem_q[rd_ptr_q];

  assign do_push = push_i && push_ready_o;
  assign do_pop  = pop_i && pop_valid_o;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 2'd1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      live_q   <= 1'b0;
    end else begin
      live_q  <= 1'b1;
      count_q <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

endmodule

// File: rtl/jtag_to_hps_bridge_b2p_adapter.sv
// Channel filter and framing repair in front of a 2-entry FIFO, with saturating
// drop and framing-error counters.
module jtag_to_hps_bridge_b2p_adapter
  import jtag_to_hps_bridge_pkg::*;
#(
  parameter int unsigned ACCEPT_CHANNEL = 0,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic [7:0]       in_channel,
  input  logic             in_startofpacket,
  input  logic             in_endofpacket,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_startofpacket,
  output logic             out_endofpacket,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] frame_err_count
);

  localparam logic [7:0] AcceptCh = 8'(ACCEPT_CHANNEL);

  frame_state_e     state_q, state_d;
  logic [CNT_W-1:0] drop_q, drop_d, ferr_q, ferr_d;
  logic             accept, match, wr_en, ferr_inc;
  beat_t            push_beat, head_beat;

  assign accept = in_valid && in_ready;
  assign match  = (in_channel == AcceptCh);

  always_comb begin
    state_d  = state_q;
    wr_en    = 1'b0;
    ferr_inc = 1'b0;
    if (accept && match) begin
      unique case (state_q)
        StIdle: begin
          if (in_startofpacket) begin
            wr_en   = 1'b1;
            state_d = in_endofpacket ? StIdle : StInPkt;
          end else begin
            ferr_inc = 1'b1;
          end
        end
        StInPkt: begin
          // A stray sop inside a packet is forwarded but counted as a repair.
          wr_en    = 1'b1;
          ferr_inc = in_startofpacket;
          state_d  = in_endofpacket ? StIdle : StInPkt;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    drop_d = drop_q;
    ferr_d = ferr_q;
    if (accept && !match && (drop_q != '1)) begin
      drop_d = drop_q + 1'b1;
    end
    if (ferr_inc && (ferr_q != '1)) begin
      ferr_d = ferr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      drop_q  <= '0;
      ferr_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      ferr_q  <= ferr_d;
    end
  end

  assign push_beat = '{data: in_data, sop: in_startofpacket, eop: in_endofpacket};

  jtag_to_hps_bridge_skid_fifo #(
    .Width($bits(beat_t))
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .push_i      (wr_en),
    .push_data_i (push_beat),
    .push_ready_o(in_ready),
    .pop_i       (out_ready),
    .pop_data_o  (head_beat),
    .pop_valid_o (out_valid)
  );

  assign out_data          = head_beat.data;
  assign out_startofpacket = head_beat.sop;
  assign out_endofpacket   = head_beat.eop;
  assign drop_count        = drop_q;
  assign frame_err_count   = ferr_q;

endmodule

// File: tb/tb_jtag_to_hps_bridge_b2p_adapter.sv
// Scoreboard bench: a behavioural model queues expected beats, a monitor checks deliveries.
module tb_jtag_to_hps_bridge_b2p_adapter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [7:0]  in_data, in_channel;
  logic        in_startofpacket, in_endofpacket;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic        out_startofpacket, out_endofpacket;
  logic [15:0] drop_count, frame_err_count;

  logic        sat_valid, sat_ready, sat_out_valid, sat_out_sop, sat_out_eop;
  logic [7:0]  sat_channel, sat_out_data;
  logic [3:0]  sat_drop, sat_ferr;

  always #5 clk = ~clk;

  jtag_to_hps_bridge_b2p_adapter #(
    .ACCEPT_CHANNEL(0),
    .CNT_W         (16)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .in_channel       (in_channel),
    .in_startofpacket (in_startofpacket),
    .in_endofpacket   (in_endofpacket),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_startofpacket(out_startofpacket),
    .out_endofpacket  (out_endofpacket),
    .drop_count       (drop_count),
    .frame_err_count  (frame_err_count)
  );

  jtag_to_hps_bridge_b2p_adapter #(
    .ACCEPT_CHANNEL(0),
    .CNT_W         (4)
  ) dut_sat (
    .clk              (clk),
    .reset_n          (reset_n),
    .in_valid         (sat_valid),
    .in_ready         (sat_ready),
    .in_data          (in_data),
    .in_channel       (sat_channel),
    .in_startofpacket (in_startofpacket),
    .in_endofpacket   (in_endofpacket),
    .out_valid        (sat_out_valid),
    .out_ready        (1'b1),
    .out_data         (sat_out_data),
    .out_startofpacket(sat_out_sop),
    .out_endofpacket  (sat_out_eop),
    .drop_count       (sat_drop),
    .frame_err_count  (sat_ferr)
  );

  typedef struct {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   lat_mode = 1'b0;
  bit   rand_on = 1'b0;
  bit   in_pkt = 1'b0;
  int   m_drop = 0;
  int   m_ferr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: applies the filtering and framing rules to each accepted beat.
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      exp_q.delete();
      in_pkt = 1'b0;
      m_drop = 0;
      m_ferr = 0;
    end else if (in_valid && in_ready) begin
      if (in_channel != 8'd0) begin
        if (m_drop < 65535) m_drop++;
      end else if (!in_pkt && !in_startofpacket) begin
        if (m_ferr < 65535) m_ferr++;
      end else begin
        if (in_pkt && in_startofpacket && m_ferr < 65535) m_ferr++;
        exp_q.push_back('{in_data, in_startofpacket, in_endofpacket,
                          lat_mode ? cyc + 1 : -1});
        in_pkt = !in_endofpacket;
      end
    end
  end

  // Monitor: every delivered beat must match the head of the expected queue.
  initial forever begin
    exp_t e;
    @(negedge clk);
    #1;
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out actual=%0h required=no_beat", out_data);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_sop", 32'(out_startofpacket), 32'(e.sop));
        check("out_eop", 32'(out_endofpacket), 32'(e.eop));
        if (e.due >= 0) check("latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [7:0] ch, input logic sop,
                      input logic eop);
    bit got = 1'b0;
    in_valid         = 1'b1;
    in_data          = d;
    in_channel       = ch;
    in_startofpacket = sop;
    in_endofpacket   = eop;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=in_ready_low required=accept");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 100 && exp_q.size() > 0; n++) @(posedge clk);
    @(negedge clk);
    #2;
    check("drain_left", 32'(exp_q.size()), 32'd0);
    check("out_valid_idle", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_channel = 8'h00;
    in_startofpacket = 1'b0;
    in_endofpacket = 1'b0;
    out_ready = 1'b0;
    sat_valid = 1'b0;
    sat_channel = 8'd5;

    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sop_eop", 32'({out_startofpacket, out_endofpacket}), 32'd0);
    check("rst_counters", 32'({drop_count, frame_err_count}), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("in_ready_before_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("in_ready_after_edge", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Basic packet at full rate with latency tracking.
    out_ready = 1'b1;
    lat_mode = 1'b1;
    send(8'h11, 8'd0, 1'b1, 1'b0);
    send(8'h22, 8'd0, 1'b0, 1'b0);
    send(8'h33, 8'd0, 1'b0, 1'b1);
    idle();
    drain();
    lat_mode = 1'b0;

    // Mismatched channel packet between two matching ones.
    send(8'h01, 8'd0, 1'b1, 1'b0);
    send(8'h02, 8'd0, 1'b0, 1'b1);
    send(8'hAA, 8'd3, 1'b1, 1'b1);
    send(8'h03, 8'd0, 1'b1, 1'b1);
    idle();
    drain();
    check("drop_count_mixed", 32'(drop_count), 32'd1);

    // Framing repairs.
    send(8'h55, 8'd0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    check("ferr_after_nosop", 32'(frame_err_count), 32'd1);
    @(posedge clk);
    #1;
    send(8'h66, 8'd0, 1'b1, 1'b0);
    send(8'h77, 8'd0, 1'b1, 1'b1);
    idle();
    drain();
    check("ferr_after_double_sop", 32'(frame_err_count), 32'd2);

    // Backpressure: continuous input while out_ready is low.
    out_ready = 1'b0;
    fork
      begin
        send(8'hB0, 8'd0, 1'b1, 1'b0);
        for (int i = 1; i < 5; i++) send(8'hB0 + 8'(i), 8'd0, 1'b0, 1'b0);
        send(8'hB5, 8'd0, 1'b0, 1'b1);
        idle();
      end
      begin
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
          @(negedge clk);
          #2;
          check("bp_head_valid", 32'(out_valid), 32'd1);
          check("bp_head_data", 32'(out_data), 32'hB0);
          if (k >= 2) check("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Randomised traffic with random backpressure.
    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(3) == 0) begin
            idle();
            @(posedge clk);
            #1;
          end
          send(8'($urandom),
               ($urandom_range(3) == 0) ? 8'($urandom_range(255, 1)) : 8'd0,
               1'($urandom_range(1)), 1'($urandom_range(1)));
        end
        idle();
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          out_ready = 1'($urandom_range(1));
          @(posedge clk);
          #1;
        end
      end
    join
    drain();
    check("drop_count_model", 32'(drop_count), 32'(m_drop));
    check("ferr_count_model", 32'(frame_err_count), 32'(m_ferr));

    // Saturating 4-bit drop counter.
    for (int i = 1; i <= 20; i++) begin
      bit got = 1'b0;
      sat_valid = 1'b1;
      for (int n = 0; n < 20 && !got; n++) begin
        @(negedge clk);
        if (sat_ready) got = 1'b1;
      end
      @(posedge clk);
      #1 sat_valid = 1'b0;
      @(negedge clk);
      check("sat_drop", 32'(sat_drop), 32'((i > 15) ? 15 : i));
      @(posedge clk);
      #1;
    end
    check("sat_ferr", 32'(sat_ferr), 32'd0);
    check("sat_out_valid", 32'(sat_out_valid), 32'd0);

    // Reset mid-packet.
    out_ready = 1'b0;
    send(8'hC1, 8'd0, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_counters", 32'({drop_count, frame_err_count}), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(8'h5A, 8'd0, 1'b0, 1'b1);
    idle();
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_out", 32'(out_valid), 32'd0);
    end
    check("post_rst_ferr", 32'(frame_err_count), 32'd1);
    check("post_rst_ferr_model", 32'(frame_err_count), 32'(m_ferr));
    check("post_rst_drop", 32'(drop_count), 32'd0);
    @(posedge clk);
    #1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
